bram_fill_copy: RTL and testbench

Command-driven memory engine that drives one write/read port pair of a simple multi-port block RAM: it fills an address range with a constant or copies a range from one address to another at one word per clock. It sits between control logic (a sprite or framebuffer manager, a CPU register interface) and the RAM. It frees the client from sequencing addresses and tracking the RAM's one-cycle read latency.

---
 rtl/bram_fill_copy.sv | 133 +++++++++++++
 tb/tb_bram_fill_copy.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_fill_copy.sv
// Fill/copy engine for one write/read port pair of a block RAM with one-cycle read latency.
// Fill writes one constant word per clock; copy primes a read, then writes one word per clock.
module bram_fill_copy #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  localparam int ADDRW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [ADDRW-1:0] cmd_src,
  input  logic [ADDRW-1:0] cmd_dst,
  input  logic [ADDRW:0]   cmd_len,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             busy,
  output logic             done,
  output logic             mem_we,
  output logic [ADDRW-1:0] mem_addr_write,
  output logic [ADDRW-1:0] mem_addr_read,
  output logic [WIDTH-1:0] mem_data_in,
  input  logic [WIDTH-1:0] mem_data_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_PRIME,
    S_COPY,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [ADDRW-1:0] src_q, src_d;
  logic [ADDRW-1:0] dst_q, dst_d;
  logic [ADDRW:0]   len_q, len_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [ADDRW:0]   cnt_q, cnt_d;
  logic [ADDRW-1:0] rd_addr_q, rd_addr_d;

  logic [ADDRW:0]   cnt_inc;
  logic             last;
  logic             accept;

  assign cnt_inc = cnt_q + 1'b1;
  assign last    = (cnt_inc == len_q);

  // The write address is an offset from the latched destination, wrapping modulo DEPTH.
  assign mem_addr_write = dst_q + cnt_q[ADDRW-1:0];
  assign mem_addr_read  = rd_addr_d;

  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    rd_addr_d   = rd_addr_q;
    busy        = 1'b0;
    done        = 1'b0;
    mem_we      = 1'b0;
    mem_data_in = data_q;
    cmd_ready   = !rst && (state_q == S_IDLE || state_q == S_DONE);
    accept      = cmd_valid && cmd_ready;

    unique case (state_q)
      S_IDLE: ;
      S_FILL: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        cnt_d  = cnt_inc;
        if (last) state_d = S_DONE;
      end
      S_PRIME: begin
        busy      = 1'b1;
        rd_addr_d = src_q;
        state_d   = S_COPY;
      end
      S_COPY: begin
        busy        = 1'b1;
        mem_we      = 1'b1;
        mem_data_in = mem_data_out;
        cnt_d       = cnt_inc;
        // Keep one read ahead of the write; stop issuing reads after the last word.
        if (last) state_d = S_DONE;
        else      rd_addr_d = src_q + cnt_inc[ADDRW-1:0];
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      src_d  = cmd_src;
      dst_d  = cmd_dst;
      len_d  = cmd_len;
      data_d = cmd_data;
      cnt_d  = '0;
      if (cmd_len == '0)  state_d = S_DONE;
      else if (cmd_op)    state_d = S_PRIME;
      else                state_d = S_FILL;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    if (rst) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
    end
  end

endmodule

// File: tb/tb_bram_fill_copy.sv
// Bench for bram_fill_copy: attached RAM, cycle-level expectation queue model and directed tests.
module tb_bram_fill_copy;
  localparam int WIDTH = 8;
  localparam int DEPTH = 256;
  localparam int ADDRW = 8;

  typedef logic [WIDTH-1:0] mem_t [DEPTH];

  function automatic mem_t ramp();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = WIDTH'(i);
    return m;
  endfunction

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_op = 1'b0;
  logic [ADDRW-1:0] cmd_src = '0;
  logic [ADDRW-1:0] cmd_dst = '0;
  logic [ADDRW:0]   cmd_len = '0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             cmd_ready, busy, done, mem_we;
  logic [ADDRW-1:0] mem_addr_write, mem_addr_read;
  logic [WIDTH-1:0] mem_data_in;
  logic [WIDTH-1:0] mem_data_out = '0;

  mem_t ram    = ramp();
  mem_t golden = ramp();

  int n_cmp = 0;
  int n_err = 0;

  bram_fill_copy #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .busy(busy), .done(done), .mem_we(mem_we),
    .mem_addr_write(mem_addr_write), .mem_addr_read(mem_addr_read),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Attached RAM: synchronous write, registered read (old data on a same-address collision).
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr_write] <= mem_data_in;
    mem_data_out <= ram[mem_addr_read];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: one record per cycle of what the outputs must be, built at acceptance.
  typedef struct packed {
    logic             we;
    logic [ADDRW-1:0] wa;
    logic [WIDTH-1:0] wd;
    logic             dn;
    logic             bz;
    logic             rchk;
    logic [ADDRW-1:0] ra;
  } exp_t;

  exp_t q[$];

  task automatic model_accept();
    exp_t e;
    int   n;
    n = int'(cmd_len);
    if (cmd_op && n > 0) begin
      e = '0; e.bz = 1'b1; e.rchk = 1'b1; e.ra = cmd_src;
      q.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      e = '0;
      e.we = 1'b1;
      e.bz = 1'b1;
      e.wa = cmd_dst + ADDRW'(i);
      e.wd = cmd_op ? golden[cmd_src + ADDRW'(i)] : cmd_data;
      if (cmd_op && i + 1 < n) begin
        e.rchk = 1'b1;
        e.ra   = cmd_src + ADDRW'(i + 1);
      end
      q.push_back(e);
    end
    e = '0; e.dn = 1'b1;
    q.push_back(e);
  endtask

  initial begin : compare_proc
    exp_t e;
    logic rdy;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("ready_in_reset", 32'(cmd_ready), 32'd0);
      end else begin
        if (q.size() > 0) e = q[0];
        else              e = '0;
        check("mem_we", 32'(mem_we), 32'(e.we));
        check("busy", 32'(busy), 32'(e.bz));
        check("done", 32'(done), 32'(e.dn));
        check("cmd_ready", 32'(cmd_ready), 32'((q.size() == 0) || e.dn));
        if (e.we) begin
          check("waddr", 32'(mem_addr_write), 32'(e.wa));
          check("wdata", 32'(mem_data_in), 32'(e.wd));
        end
        if (e.rchk) check("raddr", 32'(mem_addr_read), 32'(e.ra));
      end
      @(posedge clk);
      rdy = !rst && (q.size() == 0 || q[0].dn);
      if (q.size() > 0) begin
        if (q[0].we) golden[q[0].wa] = q[0].wd;
        void'(q.pop_front());
      end
      if (rst) q.delete();
      else if (rdy && cmd_valid) model_accept();
    end
  end

  // Activity monitor: running totals plus the cycle of the latest burst start and done pulse.
  int   cyc = 0;
  int   we_total = 0, done_total = 0, we_start = -1, done_cyc = -1;
  logic prev_we = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        we_total++;
        if (!prev_we) we_start = cyc;
      end
      if (done) begin
        done_total++;
        done_cyc = cyc;
      end
    end
    prev_we = mem_we && !rst;
  end

  int acc_cyc;

  task automatic present(input logic op, input logic [ADDRW-1:0] src, input logic [ADDRW-1:0] dst,
                         input logic [ADDRW:0] len, input logic [WIDTH-1:0] data);
    cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_data = data;
    cmd_valid = 1'b1;
  endtask

  task automatic wait_accept();
    logic r;
    logic accepted;
    accepted = 1'b0;
    for (int k = 0; k < 600 && !accepted; k++) begin
      @(negedge clk);
      r = cmd_ready;
      @(posedge clk);
      #1;
      if (r) accepted = 1'b1;
    end
    cmd_valid = 1'b0;
    acc_cyc = cyc;
    check("accept_timeout", 32'(accepted), 32'd1);
  endtask

  task automatic issue(input logic op, input logic [ADDRW-1:0] src, input logic [ADDRW-1:0] dst,
                       input logic [ADDRW:0] len, input logic [WIDTH-1:0] data);
    present(op, src, dst, len, data);
    wait_accept();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 600 && q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    check("idle_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int we0, dn0, a_acc, bad;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_waddr", 32'(mem_addr_write), 32'd0);
    check("rst_raddr", 32'(mem_addr_read), 32'd0);
    @(posedge clk); #1;

    // Basic fill
    we0 = we_total; dn0 = done_total;
    issue(1'b0, 8'h00, 8'h10, 9'd4, 8'hA5);
    wait_idle();
    check("fill_we_count", 32'(we_total - we0), 32'd4);
    check("fill_first_we", 32'(we_start - acc_cyc), 32'd0);
    check("fill_done_at", 32'(done_cyc - acc_cyc), 32'd4);
    check("fill_done_count", 32'(done_total - dn0), 32'd1);
    for (int i = 0; i < 4; i++) check("fill_ram", 32'(ram[8'h10 + i]), 32'hA5);
    check("fill_below", 32'(ram[8'h0F]), 32'h0F);
    check("fill_above", 32'(ram[8'h14]), 32'h14);

    // Copy from a preloaded ramp
    we0 = we_total;
    issue(1'b1, 8'h20, 8'h80, 9'd16, 8'h00);
    wait_idle();
    check("copy_we_count", 32'(we_total - we0), 32'd16);
    check("copy_first_we", 32'(we_start - acc_cyc), 32'd1);
    check("copy_done_at", 32'(done_cyc - acc_cyc), 32'd17);
    for (int i = 0; i < 16; i++) check("copy_ram", 32'(ram[8'h80 + i]), 32'(8'h20 + i));

    // Address wrap on fill and copy
    issue(1'b0, 8'h00, 8'hFE, 9'd4, 8'h3C);
    wait_idle();
    check("wrap_fe", 32'(ram[8'hFE]), 32'h3C);
    check("wrap_ff", 32'(ram[8'hFF]), 32'h3C);
    check("wrap_00", 32'(ram[8'h00]), 32'h3C);
    check("wrap_01", 32'(ram[8'h01]), 32'h3C);
    check("wrap_02", 32'(ram[8'h02]), 32'h02);
    issue(1'b1, 8'hFF, 8'h10, 9'd2, 8'h00);
    wait_idle();
    check("wrapcopy_10", 32'(ram[8'h10]), 32'h3C);
    check("wrapcopy_11", 32'(ram[8'h11]), 32'h3C);
    check("wrapcopy_12", 32'(ram[8'h12]), 32'hA5);

    // Zero-length commands
    we0 = we_total; dn0 = done_total;
    issue(1'b0, 8'h00, 8'h30, 9'd0, 8'h99);
    wait_idle();
    check("len0_fill_done_at", 32'(done_cyc - acc_cyc), 32'd0);
    issue(1'b1, 8'h00, 8'h31, 9'd0, 8'h00);
    wait_idle();
    check("len0_copy_done_at", 32'(done_cyc - acc_cyc), 32'd0);
    check("len0_we_count", 32'(we_total - we0), 32'd0);
    check("len0_done_count", 32'(done_total - dn0), 32'd2);
    check("len0_ram", 32'(ram[8'h30]), 32'h30);

    // Back-to-back handshake with a command held during busy
    dn0 = done_total;
    issue(1'b0, 8'h00, 8'h40, 9'd3, 8'h11);
    a_acc = acc_cyc;
    present(1'b0, 8'h00, 8'h50, 9'd2, 8'h77);
    @(posedge clk); #1;
    cmd_data = 8'h22;
    wait_accept();
    check("b2b_accept_gap", 32'(acc_cyc - a_acc), 32'd4);
    wait_idle();
    check("b2b_done_count", 32'(done_total - dn0), 32'd2);
    for (int i = 0; i < 3; i++) check("b2b_a_ram", 32'(ram[8'h40 + i]), 32'h11);
    for (int i = 0; i < 2; i++) check("b2b_b_ram", 32'(ram[8'h50 + i]), 32'h22);

    // Full-depth fill
    we0 = we_total;
    issue(1'b0, 8'h00, 8'h00, 9'd256, 8'h55);
    wait_idle();
    check("full_we_count", 32'(we_total - we0), 32'd256);
    check("full_done_at", 32'(done_cyc - acc_cyc), 32'd256);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== 8'h55) bad++;
    check("full_ram_bad_words", 32'(bad), 32'd0);

    // Reset in the middle of a copy
    issue(1'b0, 8'h00, 8'h00, 9'd16, 8'h5A);
    wait_idle();
    dn0 = done_total;
    issue(1'b1, 8'h00, 8'h80, 9'd16, 8'h00);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    check("abort_no_done", 32'(done_total - dn0), 32'd0);
    check("abort_82", 32'(ram[8'h82]), 32'h5A);
    check("abort_83", 32'(ram[8'h83]), 32'h55);
    issue(1'b0, 8'h00, 8'h90, 9'd2, 8'hC3);
    wait_idle();
    check("after_abort_done", 32'(done_total - dn0), 32'd1);
    check("after_abort_90", 32'(ram[8'h90]), 32'hC3);
    check("after_abort_91", 32'(ram[8'h91]), 32'hC3);

    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== golden[i]) bad++;
    check("ram_vs_model", 32'(bad), 32'd0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
